// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Grant values double as indices into the {d, i} request vector.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_MEM_AW = 10;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the shared RAM.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MEM_AW = DEF_MEM_AW
) ();

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a conflict the requester that
// did not win last time gets the grant.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid = |req;
    if (&req) begin
      winner = ~last;
    end else begin
      winner = req[GRANT_D];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one synchronous
// single-port RAM: IDLE -> ACCESS (RAM command) -> RESP (capture) per access.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MEM_AW = DEF_MEM_AW
) (
  input logic          clock,
  input logic          resetn,
  mem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              acc_we_q, acc_we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic              start;
  logic              start_grant;
  logic [ADDR_W-1:0] win_addr;
  logic [1:0]        arb_req;
  logic              arb_winner;
  logic              arb_valid;
  logic              unused_addr_bits;

  // A requester still holds req during its ack cycle, so mask it there to
  // avoid granting the same request twice.
  assign arb_req = {bus.d_req & ~d_ack_q, bus.i_req & ~i_ack_q};

  rr_arb2 u_rr_arb2 (
    .req    (arb_req),
    .last   (last_grant_q),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    acc_we_d     = acc_we_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    start        = 1'b0;
    start_grant  = GRANT_I;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          start       = 1'b1;
          start_grant = arb_winner;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // Only the other requester can chain straight into a new access.
        if (grant_q == GRANT_D) begin
          d_ack_d = 1'b1;
          if (!acc_we_q) d_rdata_d = bus.mem_rdata;
          if (bus.i_req) begin
            start       = 1'b1;
            start_grant = GRANT_I;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          i_ack_d   = 1'b1;
          i_rdata_d = bus.mem_rdata;
          if (bus.d_req) begin
            start       = 1'b1;
            start_grant = GRANT_D;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    win_addr = (start_grant == GRANT_D) ? bus.d_addr : bus.i_addr;

    if (start) begin
      state_d      = ST_ACCESS;
      grant_d      = start_grant;
      last_grant_d = start_grant;
      acc_we_d     = (start_grant == GRANT_D) & bus.d_we;
      mem_en_d     = 1'b1;
      mem_we_d     = (start_grant == GRANT_D) & bus.d_we;
      mem_addr_d   = win_addr[MEM_AW+1:2];
      mem_wdata_d  = bus.d_wdata;
    end
  end

  assign unused_addr_bits = ^{win_addr[1:0], win_addr[ADDR_W-1:MEM_AW+2]};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= GRANT_I;
      last_grant_q <= GRANT_D;
      acc_we_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      acc_we_q     <= acc_we_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, write/read, misaligned address,
// write-hold of d_rdata, reset abort, first conflict and round-robin streaming.
module tb_mem_arbiter;

  logic clock;
  logic resetn;
  int   compared;
  int   mismatched;

  logic [31:0] ram [0:1023];
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  mem_arbiter_if #(.ADDR_W(32), .MEM_AW(10)) bus ();

  mem_arbiter #(.ADDR_W(32), .MEM_AW(10)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural synchronous RAM with a side port for preloading words.
  always @(posedge clock) begin
    if (load_en) begin
      ram[load_addr] <= load_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic loadWord(input logic [9:0] addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic dwe,
                               input logic [31:0] daddr, input logic [31:0] dwdata);
    bus.i_req   = ireq;
    bus.i_addr  = iaddr;
    bus.d_req   = dreq;
    bus.d_we    = dwe;
    bus.d_addr  = daddr;
    bus.d_wdata = dwdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    load_en       = 1'b0;
    load_addr     = '0;
    load_data     = '0;
    bus.mem_rdata = '0;
    resetn        = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    #2;
    $display("[TB] reset state");
    checkOutput("rst_mem_en",   {31'd0, bus.mem_en}, 32'd0);
    checkOutput("rst_mem_we",   {31'd0, bus.mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {22'd0, bus.mem_addr}, 32'd0);
    checkOutput("rst_i_ack",    {31'd0, bus.i_ack}, 32'd0);
    checkOutput("rst_d_ack",    {31'd0, bus.d_ack}, 32'd0);
    checkOutput("rst_busy",     {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_i_rdata",  bus.i_rdata, 32'd0);
    checkOutput("rst_d_rdata",  bus.d_rdata, 32'd0);

    loadWord(10'd4, 32'h0000_0513);
    loadWord(10'd5, 32'h0000_0000);
    loadWord(10'd8, 32'h0000_0000);
    loadWord(10'd9, 32'h0000_0000);

    $display("[TB] single fetch from 0x10");
    resetn = 1'b1;
    applyStimulus(1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("f_acc_en",    {31'd0, bus.mem_en}, 32'd1);
    checkOutput("f_acc_we",    {31'd0, bus.mem_we}, 32'd0);
    checkOutput("f_acc_addr",  {22'd0, bus.mem_addr}, 32'd4);
    checkOutput("f_acc_busy",  {31'd0, bus.busy}, 32'd1);
    tick();
    checkOutput("f_resp_en",   {31'd0, bus.mem_en}, 32'd0);
    checkOutput("f_resp_ack",  {31'd0, bus.i_ack}, 32'd0);
    tick();
    checkOutput("f_ack",       {31'd0, bus.i_ack}, 32'd1);
    checkOutput("f_rdata",     bus.i_rdata, 32'h0000_0513);
    checkOutput("f_ack_dack",  {31'd0, bus.d_ack}, 32'd0);
    checkOutput("f_ack_busy",  {31'd0, bus.busy}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("f_after_ack", {31'd0, bus.i_ack}, 32'd0);
    checkOutput("f_after_en",  {31'd0, bus.mem_en}, 32'd0);

    $display("[TB] data write 0xDEADBEEF to 0x20");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
    tick();
    checkOutput("w_acc_en",    {31'd0, bus.mem_en}, 32'd1);
    checkOutput("w_acc_we",    {31'd0, bus.mem_we}, 32'd1);
    checkOutput("w_acc_addr",  {22'd0, bus.mem_addr}, 32'd8);
    checkOutput("w_acc_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    tick();
    checkOutput("w_resp_we",   {31'd0, bus.mem_we}, 32'd0);
    checkOutput("w_resp_ack",  {31'd0, bus.d_ack}, 32'd0);
    tick();
    checkOutput("w_ack",       {31'd0, bus.d_ack}, 32'd1);
    checkOutput("w_rdata_hold", bus.d_rdata, 32'd0);
    checkOutput("w_ack_iack",  {31'd0, bus.i_ack}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("w_ram8",      ram[8], 32'hDEAD_BEEF);
    checkOutput("w_after_ack", {31'd0, bus.d_ack}, 32'd0);

    $display("[TB] data read from 0x20");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    tick();
    checkOutput("r_acc_we",    {31'd0, bus.mem_we}, 32'd0);
    checkOutput("r_acc_addr",  {22'd0, bus.mem_addr}, 32'd8);
    tick();
    tick();
    checkOutput("r_ack",       {31'd0, bus.d_ack}, 32'd1);
    checkOutput("r_rdata",     bus.d_rdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("[TB] misaligned read from 0x23");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0023, 32'h0);
    tick();
    checkOutput("m_acc_addr",  {22'd0, bus.mem_addr}, 32'd8);
    tick();
    checkOutput("m_resp_ack",  {31'd0, bus.d_ack}, 32'd0);
    tick();
    checkOutput("m_ack",       {31'd0, bus.d_ack}, 32'd1);
    checkOutput("m_rdata",     bus.d_rdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("[TB] write keeps previous d_rdata");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0024, 32'hCAFE_F00D);
    tick();
    tick();
    tick();
    checkOutput("h_ack",       {31'd0, bus.d_ack}, 32'd1);
    checkOutput("h_rdata",     bus.d_rdata, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("h_ram9",      ram[9], 32'hCAFE_F00D);

    $display("[TB] reset during ACCESS of a write");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0014, 32'h1234_5678);
    tick();
    checkOutput("a_acc_we",    {31'd0, bus.mem_we}, 32'd1);
    checkOutput("a_acc_addr",  {22'd0, bus.mem_addr}, 32'd5);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("a_async_we",  {31'd0, bus.mem_we}, 32'd0);
    checkOutput("a_async_en",  {31'd0, bus.mem_en}, 32'd0);
    checkOutput("a_async_busy", {31'd0, bus.busy}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("a_no_dack",   {31'd0, bus.d_ack}, 32'd0);
    checkOutput("a_ram5",      ram[5], 32'd0);
    tick();
    checkOutput("a_no_dack2",  {31'd0, bus.d_ack}, 32'd0);

    $display("[TB] simultaneous first requests after reset");
    resetn = 1'b1;
    applyStimulus(1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    tick();
    checkOutput("s_acc1_addr", {22'd0, bus.mem_addr}, 32'd4);
    checkOutput("s_acc1_en",   {31'd0, bus.mem_en}, 32'd1);
    tick();
    checkOutput("s_resp1_busy", {31'd0, bus.busy}, 32'd1);
    checkOutput("s_resp1_en",  {31'd0, bus.mem_en}, 32'd0);
    tick();
    checkOutput("s_acc2_addr", {22'd0, bus.mem_addr}, 32'd8);
    checkOutput("s_acc2_en",   {31'd0, bus.mem_en}, 32'd1);
    checkOutput("s_acc2_busy", {31'd0, bus.busy}, 32'd1);
    checkOutput("s_iack",      {31'd0, bus.i_ack}, 32'd1);
    checkOutput("s_irdata",    bus.i_rdata, 32'h0000_0513);
    checkOutput("s_dack_early", {31'd0, bus.d_ack}, 32'd0);
    applyStimulus(1'b0, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    tick();
    checkOutput("s_resp2_iack", {31'd0, bus.i_ack}, 32'd0);
    checkOutput("s_resp2_dack", {31'd0, bus.d_ack}, 32'd0);
    tick();
    checkOutput("s_dack",      {31'd0, bus.d_ack}, 32'd1);
    checkOutput("s_drdata",    bus.d_rdata, 32'hDEAD_BEEF);
    checkOutput("s_end_busy",  {31'd0, bus.busy}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("[TB] both requesters held for 8 grants");
    applyStimulus(1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
    for (int g = 0; g < 8; g++) begin
      tick();
      checkOutput($sformatf("rr%0d_acc_en", g),   {31'd0, bus.mem_en}, 32'd1);
      checkOutput($sformatf("rr%0d_acc_addr", g), {22'd0, bus.mem_addr},
                  (g % 2 == 1) ? 32'd8 : 32'd4);
      checkOutput($sformatf("rr%0d_acc_iack", g), {31'd0, bus.i_ack},
                  (g % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr%0d_acc_dack", g), {31'd0, bus.d_ack},
                  (g > 0 && g % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr%0d_acc_busy", g), {31'd0, bus.busy}, 32'd1);
      if (g == 7) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
      tick();
      checkOutput($sformatf("rr%0d_resp_en", g),   {31'd0, bus.mem_en}, 32'd0);
      checkOutput($sformatf("rr%0d_resp_acks", g), {30'd0, bus.i_ack, bus.d_ack}, 32'd0);
      checkOutput($sformatf("rr%0d_resp_busy", g), {31'd0, bus.busy}, 32'd1);
    end
    tick();
    checkOutput("rr_last_dack", {31'd0, bus.d_ack}, 32'd1);
    checkOutput("rr_last_iack", {31'd0, bus.i_ack}, 32'd0);
    checkOutput("rr_last_busy", {31'd0, bus.busy}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("rr_idle_dack", {31'd0, bus.d_ack}, 32'd0);
    checkOutput("rr_idle_en",   {31'd0, bus.mem_en}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width of both requester ports.
REQ-002 Parameter MEM_AW, default 10: word-address width of the shared RAM port.
REQ-003 Port clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 Port resetn  in  1  reset, asynchronous, active-low.
REQ-005 Port i_req / i_addr  in  1 / ADDR_W  instruction-fetch request (read-only) and byte address.
REQ-006 Port i_ack / i_rdata  out  1 / 32  one-cycle fetch completion pulse and read word.
REQ-007 Port d_req / d_we / d_addr / d_wdata  in  1 / 1 / ADDR_W / 32  data request, write flag, byte address, write word.
REQ-008 Port d_ack / d_rdata  out  1 / 32  one-cycle data completion pulse and read word.
REQ-009 Port mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / MEM_AW / 32  single-port synchronous RAM command.
REQ-010 Port mem_rdata  in  32  RAM read word, valid one cycle after mem_en with mem_we=0.
REQ-011 Port busy  out  1  high in every non-IDLE state; CPU uses it to hold PC and suppress register writes.

Function
REQ-012 FSM states IDLE, ACCESS, RESP; encoding 2 bits.
REQ-013 Requests are level: a requester keeps req, addr, we and wdata stable from assertion until the cycle its ack is high.
REQ-014 IDLE: no req -> stay IDLE; one req -> latch that requester as grant, go ACCESS; both req -> round-robin winner.
REQ-015 Round-robin: winner is the requester not recorded in last_grant; last_grant updates to the winner on every IDLE/RESP->ACCESS transition.
REQ-016 ACCESS (exactly one cycle): mem_en=1, mem_addr = granted addr[MEM_AW+1:2], mem_we = d_we when grant is D else 0, mem_wdata = d_wdata; next state RESP.
REQ-017 RESP (exactly one cycle): granted ack=1; granted rdata = mem_rdata (reads); rdata is don't-care for writes but d_rdata SHALL hold its previous value.
REQ-018 Latency: req first sampled high at edge k -> ack high during cycle after edge k+2 (3 cycles request-to-ack), identical for reads and writes.
REQ-019 RESP -> ACCESS directly when the non-acked requester has req=1 (back-to-back); the acked requester's req is ignored in RESP; otherwise RESP -> IDLE.
REQ-020 mem_en, mem_we, i_ack, d_ack SHALL be 0 outside the states named above; at most one ack high in any cycle.
REQ-021 Address bits [1:0] and bits above MEM_AW+1 are ignored (no misalignment error).
REQ-022 Outputs mem_* are registered (driven from flops, not from req inputs combinationally).

Reset
REQ-023 resetn low: state=IDLE, last_grant=D (so I wins the first conflict), all outputs 0, i_rdata=d_rdata=0, immediately and asynchronously.
REQ-024 Reset during ACCESS or RESP aborts the transaction: no ack is issued and mem_we drops to 0 asynchronously; requester must re-request.
REQ-025 First grant possible at the first rising edge after resetn deasserts.

Structure
REQ-026 Shared package holds the state typedef/encoding, grant constants GRANT_I=0 / GRANT_D=1, and default ADDR_W/MEM_AW.
REQ-027 One sub-module rr_arb2: combinational 2-way round-robin pick (inputs req[1:0], last; output winner, valid).
REQ-028 Target 120-250 lines RTL total.

Verification
REQ-029 Single fetch: i_req=1, i_addr=0x0000_0010, RAM word 4 = 0x0000_0513 -> mem_addr=4 in ACCESS, i_ack with i_rdata=0x0000_0513 exactly 3 cycles after req sampled.
REQ-030 Write then read: d_we=1, d_addr=0x20, d_wdata=0xDEAD_BEEF -> one mem_we pulse at word 8, d_ack; then read 0x20 -> d_rdata=0xDEAD_BEEF.
REQ-031 Simultaneous first requests after reset -> I granted first, D in the immediately following ACCESS (RESP->ACCESS, no IDLE), acks 2 cycles apart.
REQ-032 Both requesters held continuously for 8 grants -> strict alternation I,D,I,D..., busy constantly 1, never two acks in one cycle.
REQ-033 resetn pulsed low during ACCESS of a D write -> mem_we falls within the same cycle, no d_ack, state IDLE, next conflict grants I.
REQ-034 d_addr=0x23 (misaligned) -> treated as word 8, no error, normal 3-cycle ack.
